// File: rtl/cla_pkg.sv
// Shared definitions for the 4-bit carry-look-ahead adder and its look-ahead unit.
package cla_pkg;

  localparam int unsigned WIDTH = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic pg_t make_pg(input logic a, input logic b);
    pg_t r;
    r.p = a ^ b;
    r.g = a & b;
    return r;
  endfunction

endpackage

// File: rtl/cla_logic_4.sv
// Combinational 4-bit look-ahead unit: flattened two-level carries plus group P/G.
module cla_logic_4
  import cla_pkg::*;
(
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       c0,
  output logic [4:1] c,
  output logic       grp_p,
  output logic       grp_g
);

  // Every carry is a single sum-of-products over p/g/c0; none is built from a lower carry.
  always_comb begin
    c[1] = g[0]
         | (p[0] & c0);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c0);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    grp_p = p[3] & p[2] & p[1] & p[0];
    grp_g = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/four_bit_carry_look_ahead_adder.sv
// Registered 4-bit carry-look-ahead adder with group propagate/generate outputs.
module four_bit_carry_look_ahead_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = cla_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cy_in,
  output logic [WIDTH-1:0] sum,
  output logic             cy_out,
  output logic             grp_p,
  output logic             grp_g
);

  pg_t  [3:0] pg;
  logic [3:0] p;
  logic [3:0] g;
  logic [4:1] c;
  logic [4:0] carry;
  logic [3:0] sum_next;
  logic       grp_p_next;
  logic       grp_g_next;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      pg[i] = make_pg(a[i], b[i]);
      p[i]  = pg[i].p;
      g[i]  = pg[i].g;
    end
  end

  cla_logic_4 u_cla (
    .p     (p),
    .g     (g),
    .c0    (cy_in),
    .c     (c),
    .grp_p (grp_p_next),
    .grp_g (grp_g_next)
  );

  assign carry    = {c, cy_in};
  assign sum_next = p ^ carry[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum    <= '0;
      cy_out <= 1'b0;
      grp_p  <= 1'b0;
      grp_g  <= 1'b0;
    end else begin
      sum    <= sum_next;
      cy_out <= carry[4];
      grp_p  <= grp_p_next;
      grp_g  <= grp_g_next;
    end
  end

endmodule

// File: tb/tb_four_bit_carry_look_ahead_adder.sv
// Self-checking bench: directed table, hold check, exhaustive sweep with mid-stream reset, random vectors.
module tb_four_bit_carry_look_ahead_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cy_in;
  logic [3:0] sum;
  logic       cy_out;
  logic       grp_p;
  logic       grp_g;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [6:0] exp;   // {cy_out, sum, grp_p, grp_g}
  } vec_t;

  vec_t vecs [9];

  four_bit_carry_look_ahead_adder #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cy_in  (cy_in),
    .sum    (sum),
    .cy_out (cy_out),
    .grp_p  (grp_p),
    .grp_g  (grp_g)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition; group generate is "carries out with no carry-in".
  function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [4:0] total;
    logic       gp;
    logic       gg;
    total = 5'(x) + 5'(y) + 5'(ci);
    gp    = ((x ^ y) == 4'hF);
    gg    = ((5'(x) + 5'(y)) >= 5'd16);
    return {total, gp, gg};
  endfunction

  function automatic logic [6:0] observed();
    return {cy_out, sum, grp_p, grp_g};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {cy,sum,p,g}=%b_%h_%b_%b expected %b_%h_%b_%b",
               name, act[6], act[5:2], act[1], act[0], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Drive on the falling edge, let one rising edge register, sample 1 time unit later.
  task automatic apply(input logic r, input logic [3:0] x, input logic [3:0] y, input logic ci);
    @(negedge clk);
    rst = r; a = x; b = y; cy_in = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'd11, 4'd8,  1'b0, {1'b1, 4'd3,  1'b0, 1'b1}};
    vecs[1] = '{4'd5,  4'd4,  1'b0, {1'b0, 4'd9,  1'b0, 1'b0}};
    vecs[2] = '{4'd7,  4'd6,  1'b1, {1'b0, 4'd14, 1'b0, 1'b0}};
    vecs[3] = '{4'd9,  4'd13, 1'b1, {1'b1, 4'd7,  1'b0, 1'b1}};
    vecs[4] = '{4'd10, 4'd8,  1'b1, {1'b1, 4'd3,  1'b0, 1'b1}};
    vecs[5] = '{4'd0,  4'd0,  1'b0, {1'b0, 4'd0,  1'b0, 1'b0}};
    vecs[6] = '{4'b1010, 4'b0101, 1'b1, {1'b1, 4'd0,  1'b1, 1'b0}};
    vecs[7] = '{4'b1010, 4'b0101, 1'b0, {1'b0, 4'd15, 1'b1, 1'b0}};
    vecs[8] = '{4'd15, 4'd15, 1'b1, {1'b1, 4'd15, 1'b0, 1'b1}};

    rst = 1'b1; a = 4'hF; b = 4'hF; cy_in = 1'b1;

    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 4'hF, 4'hF, 1'b1);
      check("reset", observed(), 7'b0);
    end

    for (int i = 0; i < 9; i++) begin
      apply(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("directed[%0d]", i), observed(), vecs[i].exp);
    end

    // Outputs must not follow input changes between edges.
    apply(1'b0, 4'd3, 4'd4, 1'b0);
    @(negedge clk);
    a = 4'd15; b = 4'd1; cy_in = 1'b1;
    #2;
    check("hold", observed(), model(4'd3, 4'd4, 1'b0));
    @(posedge clk);
    #1;
    check("after_hold", observed(), model(4'd15, 4'd1, 1'b1));

    for (int i = 0; i < 512; i++) begin
      logic [3:0] x;
      logic [3:0] y;
      logic       ci;
      logic [8:0] idx;
      idx = 9'(i);
      x   = idx[8:5];
      y   = idx[4:1];
      ci  = idx[0];
      if (i == 200) begin
        apply(1'b1, x, y, ci);
        check("midstream_reset", observed(), 7'b0);
      end
      apply(1'b0, x, y, ci);
      check($sformatf("sweep[%0d]", i), observed(), model(x, y, ci));
      checks++;
      if (cy_out !== (grp_g | (grp_p & ci))) begin
        errors++;
        $display("FAIL invariant[%0d]: cy_out=%b required grp_g|(grp_p&cy_in)=%b",
                 i, cy_out, grp_g | (grp_p & ci));
      end
    end

    for (int i = 0; i < 200; i++) begin
      logic [3:0] x;
      logic [3:0] y;
      logic       ci;
      x  = 4'($urandom_range(15, 0));
      y  = 4'($urandom_range(15, 0));
      ci = 1'($urandom_range(1, 0));
      apply(1'b0, x, y, ci);
      check($sformatf("random[%0d]", i), observed(), model(x, y, ci));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_carry_look_ahead_adder.md
# four_bit_carry_look_ahead_adder

Registered 4-bit carry-look-ahead adder: adds two 4-bit operands and a carry-in, and produces a 4-bit sum and a carry-out. It also exports group propagate/generate so instances can be chained by a second-level look-ahead unit. It is the leaf block of the hybrid adder, and every instance sits behind one clocked output stage.

## Interface
Parameters:
- WIDTH, 4, operand width; fixed at 4; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- a  input  4  operand A, unsigned.
- b  input  4  operand B, unsigned.
- cy_in  input  1  carry-in, bit 0.
- sum  output  4  registered (a + b + cy_in) mod 16.
- cy_out  output  1  registered carry-out, bit 4 of a + b + cy_in.
- grp_p  output  1  registered group propagate, &(a ^ b).
- grp_g  output  1  registered group generate.

## Operation
- Per-bit signals:
  - p_i = a_i ^ b_i.
  - g_i = a_i & b_i.
- Carries are flattened two-level sum-of-products. No ripple path is allowed.
  - c0 = cy_in.
  - c1 = g0 | p0c0.
  - c2 = g1 | p1g0 | p1p0c0.
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0.
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0.
- sum_i = p_i ^ c_i; cy_out = c4.
- grp_p = p3&p2&p1&p0.
- grp_g = g3 | p3g2 | p3p2g1 | p3p2p1g0. It is independent of cy_in.
- Invariant: cy_out == grp_g | (grp_p & cy_in).
- Arithmetic is unsigned modulo 16. There is no overflow flag; signed overflow is the caller's concern.
- {cy_out, sum} always equals the 5-bit value a + b + cy_in. Range is 0..31.

## Timing
- All inputs are sampled on the rising edge of clk.
- Outputs are registered; latency is exactly 1 cycle. No combinational input-to-output path exists.
- New operands are accepted every cycle. No handshake and no stall.
- On a clock edge with rst=1:
  - sum=0, cy_out=0, grp_p=0, grp_g=0.
  - The inputs on that edge are discarded.
- Reset asserted mid-stream clears all outputs on that edge.
- First valid result appears on the first edge after rst deasserts, computed from the inputs sampled at that edge.
- Between edges, outputs hold their values regardless of input changes.

## Structure
- Shared package `cla_pkg`:
  - WIDTH = 4.
  - A packed struct for the {p, g} pair.
- Natural sub-module `cla_logic_4`:
  - Purely combinational.
  - Inputs p[3:0], g[3:0], c0.
  - Outputs c[4:1], grp_p, grp_g.
  - The same unit is reused at the second level of the hybrid adder.
- Top level:
  - Forms p/g.
  - Instantiates `cla_logic_4`.
  - Forms the sum XORs.
  - Holds one output register bank with synchronous reset.

## Test plan
- Reset: hold rst=1 for 2 cycles with a=4'hF, b=4'hF, cy_in=1 -> sum=0, cy_out=0, grp_p=0, grp_g=0.
- Directed set, one per cycle, each checked one cycle later:
  - a=11, b=8, cy_in=0 -> sum=3, cy_out=1, grp_g=1.
  - a=5, b=4, cy_in=0 -> sum=9, cy_out=0.
  - a=7, b=6, cy_in=1 -> sum=14, cy_out=0.
  - a=9, b=13, cy_in=1 -> sum=7, cy_out=1.
  - a=10, b=8, cy_in=1 -> sum=3, cy_out=1.
  - a=0, b=0, cy_in=0 -> sum=0, cy_out=0.
- Full propagate chain: a=4'b1010, b=4'b0101, cy_in=1 -> sum=0, cy_out=1, grp_p=1, grp_g=0. With cy_in=0 -> sum=15, cy_out=0.
- Maximum: a=15, b=15, cy_in=1 -> sum=15, cy_out=1, grp_g=1, grp_p=0.
- Exhaustive sweep of all 512 (a, b, cy_in) combinations, one per cycle:
  - {cy_out, sum} == a + b + cy_in.
  - cy_out == grp_g | (grp_p & cy_in).
- Mid-stream reset: assert rst for one cycle during the sweep -> outputs read 0 the following cycle, then resume correct 1-cycle-latency results.
